// File: rtl/ball_motion_controller.sv
// Frame-stepped ball kinematics plus serve / life-loss / game-over sequencing.
// Optional macro BALL_SPEEDUP_EN: every 4th paddle hit shortens the step divisor.
module ball_motion_controller #(
  parameter int BIT_WIDTH   = 10,
  parameter int BALL_RADIUS = 5,
  parameter int SCREEN_W    = 640,
  parameter int FLOOR_Y     = 479,
  parameter int START_X     = 320,
  parameter int START_Y     = 100,
  parameter int STEP_DIV    = 1,
  parameter int LOST_FRAMES = 60,
  parameter int LIVES       = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frameTick,
  input  logic                 start,
  input  logic                 ballTouchingPaddle,
  input  logic                 ballTouchingFloor,
  output logic [BIT_WIDTH-1:0] ballX,
  output logic [BIT_WIDTH-1:0] ballY,
  output logic [2:0]           livesLeft,
  output logic [BIT_WIDTH-1:0] hitCount,
  output logic                 gameOver
);

  localparam int DIV_W  = $clog2(STEP_DIV + 1);
  localparam int LOST_W = $clog2(LOST_FRAMES + 1);

  localparam logic [BIT_WIDTH-1:0] X_START = BIT_WIDTH'(START_X);
  localparam logic [BIT_WIDTH-1:0] Y_START = BIT_WIDTH'(START_Y);
  localparam logic [BIT_WIDTH-1:0] EDGE_LO = BIT_WIDTH'(BALL_RADIUS);
  localparam logic [BIT_WIDTH-1:0] EDGE_HI = BIT_WIDTH'(SCREEN_W - 1 - BALL_RADIUS);
  localparam logic [BIT_WIDTH-1:0] Y_MAX   = BIT_WIDTH'(FLOOR_Y + BALL_RADIUS);
  localparam logic [DIV_W-1:0]     DIV_RST = DIV_W'(STEP_DIV);
  localparam logic [LOST_W-1:0]    LOST_END = LOST_W'(LOST_FRAMES - 1);
  localparam logic [2:0]           LIVES_RST = 3'(LIVES);

  typedef enum logic [1:0] {IDLE, MOVING, LOST, GAME_OVER} state_t;

  state_t              state;
  logic                dirX, dirY;
  logic [DIV_W-1:0]    divCnt;
  logic [LOST_W-1:0]   lostCnt;

`ifdef BALL_SPEEDUP_EN
  logic [DIV_W-1:0]    effDiv;
`else
  localparam logic [DIV_W-1:0] effDiv = DIV_RST;
`endif

  logic                stepTick;
  logic                nextDirX, nextDirY;
  logic [BIT_WIDTH-1:0] nextX, nextY;

  // Reflection and move for the current step; the wall check sees dirX after the paddle flip.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    stepTick = (state == MOVING) && frameTick && (divCnt == effDiv - DIV_W'(1));
    nextDirX = dirX ^ ballTouchingPaddle;
    nextDirY = dirY;
    if (ballX <= EDGE_LO && !nextDirX)     nextDirX = 1'b1;
    else if (ballX >= EDGE_HI && nextDirX) nextDirX = 1'b0;
    if (ballY <= EDGE_LO && !dirY)         nextDirY = 1'b1;
    nextX = nextDirX ? ballX + BIT_WIDTH'(1) : ballX - BIT_WIDTH'(1);
    if (!nextDirY)           nextY = ballY - BIT_WIDTH'(1);
    else if (ballY >= Y_MAX) nextY = Y_MAX;
    else                     nextY = ballY + BIT_WIDTH'(1);
  end

  // NOTE: all state below is sequential, so only non-blocking assignments are used.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ballX     <= X_START;
      ballY     <= Y_START;
      dirX      <= 1'b1;
      dirY      <= 1'b1;
      divCnt    <= '0;
      lostCnt   <= '0;
      livesLeft <= LIVES_RST;
      hitCount  <= '0;
      gameOver  <= 1'b0;
`ifdef BALL_SPEEDUP_EN
      effDiv    <= DIV_RST;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          state  <= MOVING;
          divCnt <= '0;
          dirX   <= 1'b1;
          dirY   <= 1'b1;
`ifdef BALL_SPEEDUP_EN
          effDiv <= DIV_RST;
`endif
        end

        MOVING: if (frameTick) begin
          if (!stepTick) begin
            divCnt <= divCnt + DIV_W'(1);
          end else begin
            divCnt <= '0;
            if (ballTouchingFloor) begin
              state     <= LOST;
              lostCnt   <= '0;
              livesLeft <= (livesLeft != 3'd0) ? livesLeft - 3'd1 : 3'd0;
            end else begin
              if (ballTouchingPaddle && hitCount != '1) begin
                hitCount <= hitCount + BIT_WIDTH'(1);
`ifdef BALL_SPEEDUP_EN
                // This hit makes the total a multiple of four.
                if (hitCount[1:0] == 2'b11 && effDiv > DIV_W'(1))
                  effDiv <= effDiv - DIV_W'(1);
`endif
              end
              dirX  <= nextDirX;
              dirY  <= nextDirY;
              ballX <= nextX;
              ballY <= nextY;
            end
          end
        end

        LOST: if (frameTick) begin
          if (lostCnt != LOST_END) begin
            lostCnt <= lostCnt + LOST_W'(1);
          end else if (livesLeft == 3'd0) begin
            state    <= GAME_OVER;
            gameOver <= 1'b1;
          end else begin
            state <= IDLE;
            ballX <= X_START;
            ballY <= Y_START;
            dirX  <= 1'b1;
            dirY  <= 1'b1;
          end
        end

        GAME_OVER: if (start) begin
          state     <= IDLE;
          gameOver  <= 1'b0;
          livesLeft <= LIVES_RST;
          hitCount  <= '0;
          ballX     <= X_START;
          ballY     <= Y_START;
          dirX      <= 1'b1;
          dirY      <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_motion_controller.sv
// Self-checking bench for ball_motion_controller: vector table, scripted corner
// sequences, and randomized play against an arithmetic reference model.
module tb_ball_motion_controller;

  localparam int XS = 320, YS = 100, R = 5, W = 640, YMAX = 479 + 5;
  localparam int DIV = 1, LOSTF = 60, NLIVES = 3, HMAX = 1023;

  logic       clk = 1'b0;
  logic       reset, frameTick, start, ballTouchingPaddle, ballTouchingFloor;
  logic [9:0] ballX, ballY, hitCount;
  logic [2:0] livesLeft;
  logic       gameOver;

  ball_motion_controller dut (
    .clk(clk), .reset(reset), .frameTick(frameTick), .start(start),
    .ballTouchingPaddle(ballTouchingPaddle), .ballTouchingFloor(ballTouchingFloor),
    .ballX(ballX), .ballY(ballY), .livesLeft(livesLeft), .hitCount(hitCount),
    .gameOver(gameOver)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Reference model: phase of play plus signed velocity per axis.
  bit inPlay, frozen, over;
  int mX, mY, vx, vy, mLives, mHits, frameAcc, frozenFrames;

  task automatic modelReset();
    inPlay = 0; frozen = 0; over = 0;
    mX = XS; mY = YS; vx = 1; vy = 1;
    mLives = NLIVES; mHits = 0; frameAcc = 0; frozenFrames = 0;
  endtask

  task automatic modelServePosition();
    mX = XS; mY = YS; vx = 1; vy = 1;
  endtask

  task automatic modelStep(input bit ft, input bit st, input bit pad, input bit flr);
    if (over) begin
      if (st) begin
        over = 0; mLives = NLIVES; mHits = 0; modelServePosition();
      end
    end else if (frozen) begin
      if (ft) begin
        frozenFrames++;
        if (frozenFrames == LOSTF) begin
          frozen = 0;
          if (mLives == 0) over = 1;
          else modelServePosition();
        end
      end
    end else if (inPlay) begin
      if (ft) begin
        frameAcc++;
        if (frameAcc == DIV) begin
          frameAcc = 0;
          if (flr) begin
            inPlay = 0; frozen = 1; frozenFrames = 0;
            if (mLives > 0) mLives--;
          end else begin
            if (pad) begin
              vx = -vx;
              if (mHits < HMAX) mHits++;
            end
            if (mX <= R && vx < 0) vx = 1;
            if (mX >= W - 1 - R && vx > 0) vx = -1;
            if (mY <= R && vy < 0) vy = 1;
            mX = mX + vx;
            mY = (mY + vy > YMAX) ? YMAX : mY + vy;
          end
        end
      end
    end else if (st) begin
      inPlay = 1; frameAcc = 0; vx = 1; vy = 1;
    end
  endtask

  task automatic tick(input bit ft, input bit st, input bit pad, input bit flr);
    frameTick = ft; start = st; ballTouchingPaddle = pad; ballTouchingFloor = flr;
    modelStep(ft, st, pad, flr);
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    reset = 1'b1; frameTick = 0; start = 0; ballTouchingPaddle = 0; ballTouchingFloor = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    modelReset();
  endtask

  task automatic checkOut(input string nm, input int x, input int y, input int l,
                          input int h, input int o);
    check({nm, ".ballX"}, int'(ballX), x);
    check({nm, ".ballY"}, int'(ballY), y);
    check({nm, ".livesLeft"}, int'(livesLeft), l);
    check({nm, ".hitCount"}, int'(hitCount), h);
    check({nm, ".gameOver"}, int'(gameOver), o);
  endtask

  task automatic checkModel(input string nm);
    checkOut(nm, mX, mY, mLives, mHits, int'(over));
  endtask

  typedef struct {
    bit ft, st, pad, flr;
    int x, y, lives, hits;
    bit over;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1, 1, 0, 0, 320, 100, 3, 0, 0};  // serve: no step on the same tick
    vecs[1] = '{1, 0, 0, 0, 321, 101, 3, 0, 0};
    vecs[2] = '{0, 0, 0, 0, 321, 101, 3, 0, 0};
    vecs[3] = '{1, 0, 1, 0, 320, 102, 3, 1, 0};  // paddle flips X
    vecs[4] = '{1, 0, 0, 0, 319, 103, 3, 1, 0};
    vecs[5] = '{1, 1, 0, 0, 318, 104, 3, 1, 0};  // start ignored while moving
    vecs[6] = '{1, 0, 1, 1, 318, 104, 2, 1, 0};  // floor wins over paddle
    vecs[7] = '{1, 0, 0, 0, 318, 104, 2, 1, 0};

    applyReset();
    checkOut("reset", 320, 100, 3, 0, 0);
    repeat (10) tick(1, 0, 0, 0);
    checkOut("idle_hold", 320, 100, 3, 0, 0);

    tick(1, 1, 0, 0);
    checkOut("serve_same_tick", 320, 100, 3, 0, 0);
    repeat (10) tick(1, 0, 0, 0);
    checkOut("serve_10", 330, 110, 3, 0, 0);
    repeat (304) tick(1, 0, 0, 0);
    checkOut("right_wall_314", 634, 414, 3, 0, 0);
    tick(1, 0, 0, 0);
    checkOut("right_wall_315", 633, 415, 3, 0, 0);

    applyReset();
    tick(0, 1, 0, 0);
    repeat (20) tick(1, 0, 0, 0);
    checkOut("pre_paddle", 340, 120, 3, 0, 0);
    tick(1, 0, 1, 0);
    checkOut("paddle_bounce", 339, 121, 3, 1, 0);

    tick(1, 0, 0, 1);
    checkOut("floor_loss", 339, 121, 2, 1, 0);
    repeat (59) tick(1, 0, 0, 0);
    repeat (3) tick(0, 1, 0, 0);
    checkOut("lost_frozen_59", 339, 121, 2, 1, 0);
    tick(1, 0, 0, 0);
    checkOut("lost_to_idle", 320, 100, 2, 1, 0);

    tick(0, 1, 0, 0);
    tick(1, 0, 0, 1);
    checkOut("second_loss", 320, 100, 1, 1, 0);
    repeat (60) tick(1, 0, 0, 0);
    checkOut("second_idle", 320, 100, 1, 1, 0);

    tick(0, 1, 0, 0);
    tick(1, 0, 1, 0);
    checkOut("third_serve_paddle", 319, 101, 1, 2, 0);
    tick(1, 0, 1, 1);
    checkOut("third_loss_prio", 319, 101, 0, 2, 0);
    repeat (59) tick(1, 0, 0, 0);
    check("pre_gameover.gameOver", int'(gameOver), 0);
    tick(1, 0, 0, 0);
    check("gameover.gameOver", int'(gameOver), 1);
    check("gameover.livesLeft", int'(livesLeft), 0);
    check("gameover.hitCount", int'(hitCount), 2);
    tick(1, 0, 0, 0);
    check("gameover_hold.gameOver", int'(gameOver), 1);
    tick(0, 1, 0, 0);
    checkOut("restart", 320, 100, 3, 0, 0);

    applyReset();
    for (int i = 0; i < 8; i++) begin
      tick(vecs[i].ft, vecs[i].st, vecs[i].pad, vecs[i].flr);
      checkOut($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].lives,
               vecs[i].hits, int'(vecs[i].over));
    end

    applyReset();
    for (int i = 0; i < 3000; i++) begin
      tick(1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0);
      checkModel($sformatf("rand%0d", i));
    end

    tick(0, 1, 0, 0);
    repeat (7) tick(1, 0, 0, 0);
    reset = 1'b1; frameTick = 1; start = 1; ballTouchingPaddle = 1; ballTouchingFloor = 1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    modelReset();
    checkOut("mid_reset", 320, 100, 3, 0, 0);
    tick(1, 0, 0, 0);
    checkModel("after_reset_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ball_motion_controller.md
# ball_motion_controller

Frame-stepped ball kinematics engine for the paddle game. It consumes `ballTouchingPaddle` and `ballTouchingFloor` from collision detection. It produces the registered `ballX`/`ballY` that feed collision detection and the renderer. It also owns serve, life-loss and game-over sequencing.

## Interface
- `BIT_WIDTH`, 10: coordinate width.
- `BALL_RADIUS`, 5: ball radius in pixels.
- `SCREEN_W`, 640: screen width in pixels.
- `FLOOR_Y`, 479: floor row. The ball rests at `FLOOR_Y+BALL_RADIUS` when lost.
- `START_X`, 320: serve X position.
- `START_Y`, 100: serve Y position.
- `STEP_DIV`, 1: number of `frameTick`s per one-pixel step. Must be ≥1.
- `LOST_FRAMES`, 60: number of frames the ball is frozen after a floor hit.
- `LIVES`, 3: lives at game start. Must be ≥1.
- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high reset.
- `frameTick` input 1: one-cycle pulse per video frame.
- `start` input 1: serve / restart request. Level-sampled.
- `ballTouchingPaddle` input 1: from collision detection, computed on current `ballX`/`ballY`.
- `ballTouchingFloor` input 1: from collision detection, computed on current `ballX`/`ballY`.
- `ballX` output BIT_WIDTH: ball centre X.
- `ballY` output BIT_WIDTH: ball centre Y.
- `livesLeft` output 3: remaining lives.
- `hitCount` output BIT_WIDTH: paddle bounces. Saturates at all-ones.
- `gameOver` output 1: high while in GAME_OVER.

## Operation
- States and transitions:
  - IDLE: ball held at (`START_X`, `START_Y`). `start`=1 → MOVING.
  - MOVING: ball steps on each step tick.
  - LOST: ball frozen; holds for `LOST_FRAMES` frameTicks.
  - GAME_OVER: `gameOver`=1; `start`=1 → IDLE.
- Step tick: a `frameTick` on which the divider counter equals `STEP_DIV-1`. The counter then wraps to 0. It counts only in MOVING and clears on entry to MOVING.
- Direction regs: `dirX` and `dirY`, each 1 = increasing, 0 = decreasing. Both are 1 after reset and after every serve.
- On a step tick in MOVING, the collision inputs and position are evaluated in priority order:
  1. `ballTouchingFloor`: go to LOST. `livesLeft` decrements. Position is not updated. Paddle input is ignored.
  2. `ballTouchingPaddle`: `dirX` inverts. `hitCount` increments, saturating.
  3. Walls:
     - `ballX ≤ BALL_RADIUS` with `dirX`=0 → `dirX`=1.
     - `ballX ≥ SCREEN_W-1-BALL_RADIUS` with `dirX`=1 → `dirX`=0.
     - `ballY ≤ BALL_RADIUS` with `dirY`=0 → `dirY`=1.
  4. Move: X and Y each change by ±1 according to the updated directions. `ballY` saturates at `FLOOR_Y+BALL_RADIUS`, so the floor equality is always reached.
- Paddle and wall reflections may occur in the same step. The wall check uses the `dirX` value after the paddle inversion.
- LOST:
  - Counts `frameTick`s. On the `LOST_FRAMES`-th tick, go to GAME_OVER if `livesLeft`=0, else to IDLE.
  - Position is reloaded to the start position and both directions set to 1 on entry to IDLE.
- GAME_OVER + `start`: `livesLeft` reloads to `LIVES`, `hitCount` clears, go to IDLE.
- `start` is ignored in MOVING and LOST.

## Timing
- All outputs are registered and update on the clock edge that samples the qualifying `frameTick` or `start`. Latency is 1 cycle.
- Collision inputs are sampled only on step ticks. Their values at any other cycle are don't-care.
- Reset values:
  - `ballX`=`START_X`, `ballY`=`START_Y`
  - `livesLeft`=`LIVES`, `hitCount`=0, `gameOver`=0
  - state IDLE, divider and LOST counters 0
- Reset mid-operation (any state) restores the reset values on the next edge and overrides all other inputs.
- `frameTick` and `start` in the same cycle in IDLE: only the transition happens. No step occurs in that cycle.

## Configuration
- Macro `BALL_SPEEDUP_EN`:
  - Defined: every 4th paddle hit reduces the effective divisor by 1, down to a minimum of 1. The effective divisor is reloaded to `STEP_DIV` on each serve.
  - Undefined: the divisor is constant at `STEP_DIV`. No extra logic is built.

## Test plan
- Reset with defaults → `ballX`=320, `ballY`=100, `livesLeft`=3, `hitCount`=0, `gameOver`=0. Ten `frameTick`s without `start` → no position change.
- `start`, then 10 `frameTick`s with collisions low → `ballX`=330, `ballY`=110.
- Right wall, collisions low:
  - After 314 steps → `ballX`=634, `ballY`=414.
  - Step 315 → `ballX`=633, `ballY`=415.
- Paddle bounce: in MOVING, assert `ballTouchingPaddle` on one step tick at `ballX`=340 → `ballX`=339 next cycle, `hitCount`=1.
- Floor loss:
  - `ballTouchingFloor` on a step tick → `livesLeft`=2, position frozen for 60 frameTicks.
  - Then IDLE with `ballX`=320, `ballY`=100.
- Game over and priority:
  - Assert paddle and floor together on the third loss → `hitCount` unchanged, `livesLeft`=0, `gameOver`=1 after 60 ticks.
  - `start` → `livesLeft`=3, `gameOver`=0.
